// File: rtl/spmv_m10k_read_arbiter.sv
// ============================================================================
// Module   : spmv_m10k_read_arbiter
// Purpose  : Shares the two single-port M10K read buses (A: loaders 0/1,
//            B: loaders 2/3) among the CSR buffer loaders, tags each issued
//            read, routes returned data back to its loader and sequences the
//            READ phase (IDLE -> RUN -> DRAIN -> DONE).
// Options  : SPMV_ARB_PERF_EN adds per-port contention counters
//            (o_conflict_A / o_conflict_B).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spmv_m10k_read_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic [3:0]            i_req,
    input  logic [4*ADDR_W-1:0]   i_addr,
    input  logic [3:0]            i_done,
    output logic [3:0]            o_gnt,
    output logic [ADDR_W-1:0]     o_addr_A,
    output logic [ADDR_W-1:0]     o_addr_B,
    input  logic [DATA_W-1:0]     i_read_data_A,
    input  logic [DATA_W-1:0]     i_read_data_B,
    output logic [DATA_W-1:0]     o_rdata_A,
    output logic [DATA_W-1:0]     o_rdata_B,
    output logic [3:0]            o_rvalid,
    output logic                  o_busy,
`ifdef SPMV_ARB_PERF_EN
    output logic [15:0]           o_conflict_A,
    output logic [15:0]           o_conflict_B,
`endif
    output logic                  o_read_done
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [3:0]        r_done;
    logic              r_last_A;   // 1: odd requester (1) was granted last on port A
    logic              r_last_B;   // 1: odd requester (3) was granted last on port B
    logic [RD_LAT:0]   r_vld_A;
    logic [RD_LAT:0]   r_sel_A;    // 1: read belongs to the odd requester
    logic [RD_LAT:0]   r_vld_B;
    logic [RD_LAT:0]   r_sel_B;

    logic              w_start_acc;
    logic              w_run;
    logic [3:0]        w_act;
    logic [3:0]        w_gnt;
    logic              w_gnt_A;
    logic              w_gnt_B;
    logic              w_pipe_empty;

    assign w_start_acc  = (r_state == c_IDLE) && i_start;
    assign w_run        = (r_state == c_RUN);
    // Loaders already marked done no longer compete; grants only happen in RUN
    assign w_act        = i_req & ~r_done & {4{w_run}};

    // Round-robin between the two requesters of each port; a lone requester always wins
    assign w_gnt[0] = w_act[0] & (~w_act[1] |  r_last_A);
    assign w_gnt[1] = w_act[1] & (~w_act[0] | ~r_last_A);
    assign w_gnt[2] = w_act[2] & (~w_act[3] |  r_last_B);
    assign w_gnt[3] = w_act[3] & (~w_act[2] | ~r_last_B);

    assign w_gnt_A      = w_gnt[0] | w_gnt[1];
    assign w_gnt_B      = w_gnt[2] | w_gnt[3];
    assign w_pipe_empty = ~(|r_vld_A) & ~(|r_vld_B);

    assign o_gnt        = w_gnt;
    assign o_rdata_A    = i_read_data_A;
    assign o_rdata_B    = i_read_data_B;
    assign o_busy       = (r_state == c_RUN) || (r_state == c_DRAIN);
    assign o_read_done  = (r_state == c_DONE);

    // The last tag stage lines up with the cycle the M10K word is on the bus
    assign o_rvalid[0]  = r_vld_A[RD_LAT] & ~r_sel_A[RD_LAT];
    assign o_rvalid[1]  = r_vld_A[RD_LAT] &  r_sel_A[RD_LAT];
    assign o_rvalid[2]  = r_vld_B[RD_LAT] & ~r_sel_B[RD_LAT];
    assign o_rvalid[3]  = r_vld_B[RD_LAT] &  r_sel_B[RD_LAT];

    // Phase sequencer; i_done is folded in so RUN can end the cycle the last strobe arrives
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:  if (i_start) r_state <= c_RUN;
                c_RUN:   if (&(r_done | i_done)) r_state <= c_DRAIN;
                c_DRAIN: if (w_pipe_empty) r_state <= c_DONE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Sticky per-loader done bits, cleared when a new phase starts
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_done <= 4'b0000;
        end else if (w_start_acc) begin
            r_done <= 4'b0000;
        end else if (w_run) begin
            r_done <= r_done | i_done;
        end
    end

    // Last-grant memory, M10K address registers and tag pipelines
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_last_A <= 1'b1;
            r_last_B <= 1'b1;
            o_addr_A <= '0;
            o_addr_B <= '0;
            r_vld_A  <= '0;
            r_sel_A  <= '0;
            r_vld_B  <= '0;
            r_sel_B  <= '0;
        end else begin
            if (w_gnt_A) begin
                r_last_A <= w_gnt[1];
                o_addr_A <= w_gnt[1] ? i_addr[1*ADDR_W +: ADDR_W] : i_addr[0*ADDR_W +: ADDR_W];
            end
            if (w_gnt_B) begin
                r_last_B <= w_gnt[3];
                o_addr_B <= w_gnt[3] ? i_addr[3*ADDR_W +: ADDR_W] : i_addr[2*ADDR_W +: ADDR_W];
            end
            r_vld_A <= {r_vld_A[RD_LAT-1:0], w_gnt_A};
            r_sel_A <= {r_sel_A[RD_LAT-1:0], w_gnt[1]};
            r_vld_B <= {r_vld_B[RD_LAT-1:0], w_gnt_B};
            r_sel_B <= {r_sel_B[RD_LAT-1:0], w_gnt[3]};
        end
    end

`ifdef SPMV_ARB_PERF_EN
    logic [15:0] r_conf_A;
    logic [15:0] r_conf_B;

    assign o_conflict_A = r_conf_A;
    assign o_conflict_B = r_conf_B;

    // Saturating count of RUN cycles where both live requesters of a port collide
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_conf_A <= 16'h0000;
            r_conf_B <= 16'h0000;
        end else if (w_start_acc) begin
            r_conf_A <= 16'h0000;
            r_conf_B <= 16'h0000;
        end else begin
            if (w_act[0] && w_act[1] && (r_conf_A != 16'hFFFF)) r_conf_A <= r_conf_A + 16'd1;
            if (w_act[2] && w_act[3] && (r_conf_B != 16'hFFFF)) r_conf_B <= r_conf_B + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_spmv_m10k_read_arbiter.sv
`default_nettype none

module tb_spmv_m10k_read_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 2;

    logic                clk;
    logic                rstn;
    logic                start;
    logic [3:0]          req;
    logic [4*ADDR_W-1:0] addr;
    logic [3:0]          done;
    logic [3:0]          gnt;
    logic [ADDR_W-1:0]   addr_A, addr_B;
    logic [DATA_W-1:0]   rd_A, rd_B, rdata_A, rdata_B;
    logic [3:0]          rvalid;
    logic                busy, read_done;
`ifdef SPMV_ARB_PERF_EN
    logic [15:0]         conf_A, conf_B;
`endif

    int checks = 0;
    int errors = 0;

    spmv_m10k_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_req(req), .i_addr(addr),
        .i_done(done), .o_gnt(gnt), .o_addr_A(addr_A), .o_addr_B(addr_B),
        .i_read_data_A(rd_A), .i_read_data_B(rd_B),
        .o_rdata_A(rdata_A), .o_rdata_B(rdata_B), .o_rvalid(rvalid), .o_busy(busy),
`ifdef SPMV_ARB_PERF_EN
        .o_conflict_A(conf_A), .o_conflict_B(conf_B),
`endif
        .o_read_done(read_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // M10K model: registered address + 2-cycle read; contents are an address hash
    logic [DATA_W-1:0] mA1, mA2, mB1, mB2;
    always @(posedge clk) begin
        mA1 <= {6'd0, addr_A} ^ 16'hA5A5;
        mA2 <= mA1;
        mB1 <= {6'd0, addr_B} + 16'h1000;
        mB2 <= mB1;
    end
    assign rd_A = mA2;
    assign rd_B = mB2;

    // Advance to the next cycle; inputs change 1 time unit after the edge
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; req = 4'b0; done = 4'b0; addr = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        nxt(); nxt();
        rstn = 1'b1;
        nxt();
    endtask

    // Cycle 0 of a phase: assert start; returns at the start of cycle 1
    task automatic begin_phase();
        start = 1'b1;
        nxt();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (rvalid !== 4'b0 || busy !== 1'b0 || read_done !== 1'b0 || addr_A !== '0 || addr_B !== '0) begin
            errors++;
            $display("FAIL reset_state: rvalid=%b busy=%b done=%b addrA=%h addrB=%h, required 0 0 0 000 000",
                     rvalid, busy, read_done, addr_A, addr_B);
        end
        req = 4'b0001; addr[9:0] = 10'h005;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL idle_no_grant: gnt=%b, required 0000", gnt);
        end
        idle_inputs();
    endtask

    task automatic test_single();
        do_reset();
        begin_phase();          // cycle 1
        nxt();                  // cycle 2
        req = 4'b0001; addr[9:0] = 10'h005;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: gnt=%b, required 0001", gnt); end
        nxt(); idle_inputs();   // cycle 3
        #1;
        checks++;
        if (addr_A !== 10'h005) begin errors++; $display("FAIL single_addr: addr_A=%h, required 005", addr_A); end
        nxt();                  // cycle 4
        checks++;
        if (rvalid !== 4'b0000) begin errors++; $display("FAIL single_early: rvalid=%b, required 0000", rvalid); end
        nxt();                  // cycle 5
        checks++;
        if (rvalid !== 4'b0001 || rdata_A !== 16'hA5A0) begin
            errors++; $display("FAIL single_rvalid: rvalid=%b rdata=%h, required 0001 a5a0", rvalid, rdata_A);
        end
    endtask

    task automatic test_tie();
        logic [3:0]  exp_g [4];
        logic [9:0]  exp_a [4];
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0001; exp_g[3] = 4'b0010;
        exp_a[0] = 10'h011; exp_a[1] = 10'h022; exp_a[2] = 10'h011; exp_a[3] = 10'h022;
        do_reset();
        begin_phase();
        for (int c = 0; c < 4; c++) begin   // cycles 1..4
            req = 4'b0011; addr[9:0] = 10'h011; addr[19:10] = 10'h022;
            #1;
            checks++;
            if (gnt !== exp_g[c]) begin errors++; $display("FAIL tie_gnt[%0d]: gnt=%b, required %b", c, gnt, exp_g[c]); end
            if (c > 0) begin
                checks++;
                if (addr_A !== exp_a[c-1]) begin errors++; $display("FAIL tie_addr[%0d]: addr_A=%h, required %h", c, addr_A, exp_a[c-1]); end
            end
            if (c == 3) begin
                checks++;
                if (rvalid !== 4'b0001 || rdata_A !== (16'h0011 ^ 16'hA5A5)) begin
                    errors++; $display("FAIL tie_rv0: rvalid=%b rdata=%h, required 0001 a5b4", rvalid, rdata_A);
                end
            end
            nxt();
        end
        idle_inputs();          // cycle 5
        #1;
        checks++;
        if (addr_A !== 10'h022 || rvalid !== 4'b0010 || rdata_A !== (16'h0022 ^ 16'hA5A5)) begin
            errors++; $display("FAIL tie_tail: addr_A=%h rvalid=%b rdata=%h, required 022 0010 a587", addr_A, rvalid, rdata_A);
        end
`ifdef SPMV_ARB_PERF_EN
        checks++;
        if (conf_A !== 16'd4 || conf_B !== 16'd0) begin
            errors++; $display("FAIL tie_conflict: A=%0d B=%0d, required 4 0", conf_A, conf_B);
        end
`endif
    endtask

    task automatic test_ports();
        do_reset();
        begin_phase();          // cycle 1
        req = 4'b0110; addr[19:10] = 10'h033; addr[29:20] = 10'h044;
        #1;
        checks++;
        if (gnt !== 4'b0110) begin errors++; $display("FAIL ports_gnt: gnt=%b, required 0110", gnt); end
        nxt(); idle_inputs();   // cycle 2
        checks++;
        if (addr_A !== 10'h033 || addr_B !== 10'h044) begin
            errors++; $display("FAIL ports_addr: A=%h B=%h, required 033 044", addr_A, addr_B);
        end
        nxt(); nxt();           // cycle 4
        checks++;
        if (rvalid !== 4'b0110 || rdata_B !== 16'h1044) begin
            errors++; $display("FAIL ports_rvalid: rvalid=%b rdata_B=%h, required 0110 1044", rvalid, rdata_B);
        end
    endtask

    task automatic test_drain();
        int pulses;
        do_reset();
        begin_phase();          // cycle 1: last grant with every done strobe
        req = 4'b1000; addr[39:30] = 10'h077; done = 4'b1111;
        #1;
        checks++;
        if (gnt !== 4'b1000 || busy !== 1'b1) begin errors++; $display("FAIL drain_gnt: gnt=%b busy=%b, required 1000 1", gnt, busy); end
        nxt(); idle_inputs();   // cycle 2
        pulses = 0;
        for (int c = 2; c <= 9; c++) begin
            if (c <= 5) begin
                checks++;
                if (busy !== 1'b1 || read_done !== 1'b0) begin
                    errors++; $display("FAIL drain_busy[%0d]: busy=%b done=%b, required 1 0", c, busy, read_done);
                end
            end
            if (c == 4) begin
                checks++;
                if (rvalid !== 4'b1000 || rdata_B !== 16'h1077) begin
                    errors++; $display("FAIL drain_rvalid: rvalid=%b rdata_B=%h, required 1000 1077", rvalid, rdata_B);
                end
            end
            if (c == 6) begin
                checks++;
                if (read_done !== 1'b1 || busy !== 1'b0) begin
                    errors++; $display("FAIL drain_done: done=%b busy=%b, required 1 0", read_done, busy);
                end
            end
            if (read_done === 1'b1) pulses++;
            nxt();
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL drain_pulses: %0d, required 1", pulses); end
    endtask

    task automatic test_min_phase();
        do_reset();
        begin_phase();          // cycle 1
        done = 4'b1111;
        nxt(); idle_inputs();   // cycle 2: DRAIN, pipe empty
        checks++;
        if (busy !== 1'b1 || read_done !== 1'b0) begin errors++; $display("FAIL min_drain: busy=%b done=%b, required 1 0", busy, read_done); end
        nxt();                  // cycle 3
        checks++;
        if (read_done !== 1'b1) begin errors++; $display("FAIL min_done: done=%b, required 1", read_done); end
        nxt();                  // cycle 4
        checks++;
        if (read_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL min_idle: done=%b busy=%b, required 0 0", read_done, busy); end
    endtask

    task automatic test_mask();
        do_reset();
        begin_phase();          // cycle 1
        done = 4'b1000;
        start = 1'b1;           // ignored outside IDLE
        nxt(); idle_inputs();   // cycle 2
        req = 4'b1000; addr[39:30] = 10'h0AA;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL mask_gnt: gnt=%b, required 0000", gnt); end
        nxt();                  // cycle 3
        req = 4'b1100; addr[29:20] = 10'h0BB; addr[39:30] = 10'h0AA;
        #1;
        checks++;
        if (gnt !== 4'b0100) begin errors++; $display("FAIL mask_other: gnt=%b, required 0100", gnt); end
        nxt();                  // cycle 4
        req = 4'b1000;
        #1;
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b1 || addr_B !== 10'h0BB) begin
            errors++; $display("FAIL mask_hold: gnt=%b busy=%b addr_B=%h, required 0000 1 0bb", gnt, busy, addr_B);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        begin_phase();          // cycle 1
        req = 4'b0101; addr[9:0] = 10'h0C1; addr[29:20] = 10'h0C2;
        nxt();                  // cycle 2
        req = 4'b1010; addr[19:10] = 10'h0D1; addr[39:30] = 10'h0D2;
        nxt(); idle_inputs();   // cycle 3
        rstn = 1'b0;
        #1;
        checks++;
        if (rvalid !== 4'b0 || busy !== 1'b0 || addr_A !== '0 || addr_B !== '0) begin
            errors++; $display("FAIL rstmid_async: rvalid=%b busy=%b A=%h B=%h, required 0 0 000 000", rvalid, busy, addr_A, addr_B);
        end
        nxt();                  // cycle 4
        rstn = 1'b1;
        for (int c = 4; c <= 6; c++) begin
            #1;
            checks++;
            if (rvalid !== 4'b0 || busy !== 1'b0 || addr_A !== '0) begin
                errors++; $display("FAIL rstmid_after[%0d]: rvalid=%b busy=%b A=%h, required 0 0 000", c, rvalid, busy, addr_A);
            end
            nxt();
        end
    endtask

    initial begin
        rstn = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_tie();
        test_ports();
        test_drain();
        test_min_phase();
        test_mask();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
